// File: rtl/mux9_rr_collector.sv
// mux9_rr_collector: registered 9:1 round-robin merge of nine valid/ready
// channels into one output stream. Each output word carries its 0..8 source
// index, so a downstream 1x9 demux can route it back by channel number.
module mux9_rr_collector #(
    parameter int DW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [8:0]      i_chan_en,
    input  logic [8:0]      i_in_valid,
    input  logic [9*DW-1:0] i_in_data,
    output logic [8:0]      o_in_ready,
    output logic            o_out_valid,
    output logic [DW-1:0]   o_out_data,
    output logic [3:0]      o_out_sel,
    input  logic            i_out_ready
);

    localparam int NCH = 9;

    // Round-robin search: first requester at or after ptr, wrapping mod 9.
    // Returns {found, index}.
    function automatic logic [4:0] rr_pick(input logic [8:0] req,
                                           input logic [3:0] ptr);
        logic       found;
        logic [3:0] idx;
        logic [4:0] cand;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, ptr} + 5'(i);
            if (cand >= 5'(NCH)) begin
                cand = cand - 5'(NCH);
            end
            if (!found && req[cand[3:0]]) begin
                found = 1'b1;
                idx   = cand[3:0];
            end
        end
        return {found, idx};
    endfunction

    // Pointer moves to the channel just after the granted one.
    function automatic logic [3:0] next_ptr(input logic [3:0] g);
        return (g == 4'(NCH - 1)) ? 4'd0 : g + 4'd1;
    endfunction

    logic [8:0]    w_req;
    logic [4:0]    w_pick;
    logic          w_found;
    logic [3:0]    w_grant;
    logic          w_load;
    logic [DW-1:0] w_grant_data;

    logic          r_vld_p1;
    logic [DW-1:0] r_out_data_p1;
    logic [3:0]    r_out_sel_p1;
    logic [3:0]    r_ptr;

    assign w_req   = i_in_valid & i_chan_en;
    assign w_pick  = rr_pick(w_req, r_ptr);
    assign w_found = w_pick[4];
    assign w_grant = w_pick[3:0];
    // Load when something is requested and the output slot is free or
    // draining this cycle; reset blocks every input handshake.
    assign w_load  = !i_rst && w_found && (!r_vld_p1 || i_out_ready);

    // One-hot ready to the granted channel only on a load cycle.
    always_comb begin
        o_in_ready = '0;
        if (w_load) begin
            o_in_ready[w_grant] = 1'b1;
        end
    end

    // Select the granted channel's data word.
    always_comb begin
        w_grant_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_grant == 4'(k)) begin
                w_grant_data = i_in_data[k*DW +: DW];
            end
        end
    end

    // ---- stage p0 -> p1: output register and round-robin pointer ----
    // Load on grant, otherwise drop valid when the held word drains.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p1      <= 1'b0;
            r_out_data_p1 <= '0;
            r_out_sel_p1  <= 4'd0;
            r_ptr         <= 4'd0;
        end else if (w_load) begin
            r_vld_p1      <= 1'b1;
            r_out_data_p1 <= w_grant_data;
            r_out_sel_p1  <= w_grant;
            r_ptr         <= next_ptr(w_grant);
        end else if (r_vld_p1 && i_out_ready) begin
            r_vld_p1      <= 1'b0;
        end
    end

    assign o_out_valid = r_vld_p1;
    assign o_out_data  = r_out_data_p1;
    assign o_out_sel   = r_out_sel_p1;

endmodule
